// File: rtl/array3d_frame_pkg.sv
// Shared types and helpers for the 3-D frame summer: FSM encoding, index widths,
// and the element-to-accumulator sign extension.
package array3d_frame_pkg;

    localparam int DEF_D0 = 2;
    localparam int DEF_D1 = 3;
    localparam int DEF_D2 = 4;
    localparam int DEF_W  = 16;
    localparam int DEF_SW = 32;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        SUM  = 2'd1,
        HOLD = 2'd2
    } state_e;

    // A dimension of size 1 still needs a 1-bit index.
    function automatic int idx_w(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

    typedef logic [idx_w(DEF_D0)-1:0] idx0_t;
    typedef logic [idx_w(DEF_D1)-1:0] idx1_t;
    typedef logic [idx_w(DEF_D2)-1:0] idx2_t;

    function automatic logic [DEF_SW-1:0] sext(input logic [DEF_W-1:0] x);
        return {{(DEF_SW-DEF_W){x[DEF_W-1]}}, x};
    endfunction

endpackage

// File: rtl/array3d_frame_summer_if.sv
// Element input stream and frame-sum output stream of the 3-D frame summer.
interface array3d_frame_summer_if #(
    parameter int W  = 16,
    parameter int SW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_sum;
    logic          out_err;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_err
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_err
    );
endinterface

// File: rtl/array3d_index_walker.sv
// Row-major (i outer, k inner) wrap counter over a D0 x D1 x D2 array.
module array3d_index_walker
    import array3d_frame_pkg::*;
#(
    parameter int D0  = DEF_D0,
    parameter int D1  = DEF_D1,
    parameter int D2  = DEF_D2,
    parameter int IW0 = idx_w(D0),
    parameter int IW1 = idx_w(D1),
    parameter int IW2 = idx_w(D2)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           step,
    output logic [IW0-1:0] i,
    output logic [IW1-1:0] j,
    output logic [IW2-1:0] k,
    output logic           at_end
);
    localparam logic [IW0-1:0] LAST_I = IW0'(D0 - 1);
    localparam logic [IW1-1:0] LAST_J = IW1'(D1 - 1);
    localparam logic [IW2-1:0] LAST_K = IW2'(D2 - 1);

    assign at_end = (i == LAST_I) && (j == LAST_J) && (k == LAST_K);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (step) begin
            if (k == LAST_K) begin
                k <= '0;
                if (j == LAST_J) begin
                    j <= '0;
                    i <= (i == LAST_I) ? '0 : i + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
            end else begin
                k <= k + 1'b1;
            end
        end
    end
endmodule

// File: rtl/array3d_frame_summer.sv
// Captures one frame into a 3-D buffer, then sums every element (sign-extended)
// one per cycle and offers the total on a valid/ready output.
module array3d_frame_summer
    import array3d_frame_pkg::*;
#(
    parameter int D0 = DEF_D0,
    parameter int D1 = DEF_D1,
    parameter int D2 = DEF_D2,
    parameter int W  = DEF_W,
    parameter int SW = DEF_SW
) (
    input  logic                   clk,
    input  logic                   rst,
    array3d_frame_summer_if.slave  bus
);
    localparam int IW0 = idx_w(D0);
    localparam int IW1 = idx_w(D1);
    localparam int IW2 = idx_w(D2);

    localparam logic [1:0] ST_FILL = FILL;
    localparam logic [1:0] ST_SUM  = SUM;
    localparam logic [1:0] ST_HOLD = HOLD;

    logic [1:0]     state_reg;
    logic [SW-1:0]  acc_reg;
    logic [SW-1:0]  sum_reg;
    logic           err_reg;
    logic           out_err_reg;
    logic [W-1:0]   buf_mem [D0][D1][D2];

    logic [IW0-1:0] i;
    logic [IW1-1:0] j;
    logic [IW2-1:0] k;
    logic           at_end;

    logic           in_fill, in_sum, in_hold;
    logic           accept, frame_done, take_out;
    logic           walk_clear, walk_step;
    logic [SW-1:0]  acc_next;

    assign in_fill    = (state_reg == ST_FILL);
    assign in_sum     = (state_reg == ST_SUM);
    assign in_hold    = (state_reg == ST_HOLD);
    assign accept     = in_fill && bus.in_valid;
    assign frame_done = accept && (bus.in_last || at_end);
    assign take_out   = in_hold && bus.out_ready;
    assign acc_next   = acc_reg + sext(buf_mem[i][j][k]);

    // One walker serves both the fill and the sum pass.
    assign walk_clear = frame_done || (in_sum && at_end) || take_out;
    assign walk_step  = (accept && !frame_done) || (in_sum && !at_end);

    array3d_index_walker #(.D0(D0), .D1(D1), .D2(D2)) u_walker (
        .clk    (clk),
        .rst    (rst),
        .clear  (walk_clear),
        .step   (walk_step),
        .i      (i),
        .j      (j),
        .k      (k),
        .at_end (at_end)
    );

    // Whole-array clear on result handoff keeps short frames zero-padded.
    always_ff @(posedge clk) begin
        if (rst || take_out) begin
            for (int a = 0; a < D0; a++)
                for (int b = 0; b < D1; b++)
                    for (int c = 0; c < D2; c++)
                        buf_mem[a][b][c] <= '0;
        end else if (accept) begin
            buf_mem[i][j][k] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_FILL;
            acc_reg     <= '0;
            sum_reg     <= '0;
            err_reg     <= 1'b0;
            out_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_FILL: begin
                    if (frame_done) begin
                        err_reg   <= bus.in_last ^ at_end;
                        acc_reg   <= '0;
                        state_reg <= ST_SUM;
                    end
                end
                ST_SUM: begin
                    acc_reg <= acc_next;
                    if (at_end) begin
                        sum_reg     <= acc_next;
                        out_err_reg <= err_reg;
                        state_reg   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready)
                        state_reg <= ST_FILL;
                end
                default: state_reg <= ST_FILL;
            endcase
        end
    end

    assign bus.in_ready  = in_fill;
    assign bus.out_valid = in_hold;
    assign bus.out_sum   = sum_reg;
    assign bus.out_err   = out_err_reg;
endmodule

// File: tb/tb_array3d_frame_summer.sv
// Directed bench for array3d_frame_summer (2x3x4 array, 16-bit elements, 32-bit sum).
module tb_array3d_frame_summer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    array3d_frame_summer_if #(.W(16), .SW(32)) bus ();

    array3d_frame_summer #(.D0(2), .D1(3), .D2(4), .W(16), .SW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] frame_vals [24];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s: got %h", tag, got);
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_elem(input string tag, input logic [15:0] d, input logic last);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!bus.in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.in_ready)
            check_val({tag, "_accept_timeout"}, 32'(waited), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int n, input int last_at, input bit gapped,
                             input int hold, input logic [31:0] exp_sum, input logic exp_err);
        int cyc;
        for (int e = 0; e < n; e++) begin
            send_elem(tag, frame_vals[e], e == last_at);
            if (gapped && e != n - 1) begin
                @(posedge clk); #1;
            end
        end
        // cycle 1 is the one right after the last accept edge
        cyc = 1;
        while (!bus.out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_val({tag, "_latency"}, 32'(cyc), 32'd25);
        check_val({tag, "_sum"}, bus.out_sum, exp_sum);
        check_val({tag, "_err"}, 32'(bus.out_err), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = h[0] ? 1'b0 : 1'b1;
            bus.in_data  = 16'h7777;
            @(posedge clk); #1;
            check_val({tag, "_hold_sum"}, bus.out_sum, exp_sum);
            check_val({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
            check_val({tag, "_hold_out_valid"}, 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_val({tag, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
        check_val({tag, "_post_out_valid"}, 32'(bus.out_valid), 32'd0);
        check_val({tag, "_post_sum_kept"}, bus.out_sum, exp_sum);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_out_sum", bus.out_sum, 32'd0);
        check_val("rst_out_err", 32'(bus.out_err), 32'd0);

        // two ones at flat positions 11 and 23
        for (int e = 0; e < 24; e++) frame_vals[e] = 16'd0;
        frame_vals[11] = 16'd1;
        frame_vals[23] = 16'd1;
        run_frame("sparse", 24, 23, 1'b0, 0, 32'd2, 1'b0);

        for (int e = 0; e < 24; e++) frame_vals[e] = 16'hFFFF;
        run_frame("neg", 24, 23, 1'b0, 0, 32'hFFFF_FFE8, 1'b0);

        // reset during the sum pass
        for (int e = 0; e < 24; e++) frame_vals[e] = 16'd1;
        for (int e = 0; e < 24; e++) send_elem("abort", frame_vals[e], e == 23);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check_val("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("midrst_out_sum", bus.out_sum, 32'd0);
        check_val("midrst_out_err", 32'(bus.out_err), 32'd0);

        for (int e = 0; e < 24; e++) frame_vals[e] = 16'(e + 1);
        run_frame("short", 6, 5, 1'b0, 0, 32'd21, 1'b1);

        for (int e = 0; e < 24; e++) frame_vals[e] = 16'd1;
        run_frame("nolast", 24, -1, 1'b0, 0, 32'd24, 1'b1);

        for (int e = 0; e < 24; e++) frame_vals[e] = 16'd3;
        run_frame("bp", 24, 23, 1'b0, 10, 32'd72, 1'b0);

        for (int e = 0; e < 24; e++) frame_vals[e] = 16'd2;
        run_frame("twos", 24, 23, 1'b0, 0, 32'd48, 1'b0);

        for (int e = 0; e < 24; e++) frame_vals[e] = 16'(e);
        run_frame("gapped", 24, 23, 1'b1, 0, 32'd276, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d/%0d expected completion", n_pass, n_checks);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/array3d_frame_summer.md
Name: array3d_frame_summer

Overview:
- Sequential producer/consumer stage around a 3-D unpacked array `buf[D0][D1][D2]` of W-bit signed elements.
- Accepts a frame of elements over a valid/ready stream in row-major order (i outer, j middle, k inner). It stores the frame, then walks the array one element per cycle.
- Each element is sign-extended to SW bits and accumulated. The frame total is presented on a valid/ready output.
- Upstream of any consumer of per-frame array sums; it is the hardware counterpart of a nested foreach sum.

Parameters:
- D0, 2, outer dimension size (>=1)
- D1, 3, middle dimension size (>=1)
- D2, 4, inner dimension size (>=1)
- W, 16, element width in bits, two's complement
- SW, 32, accumulator/result width in bits (SW > W)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  element available
- in_ready  output  1  block can accept an element
- in_data  input  W  element value, signed
- in_last  input  1  marks final element of frame
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_sum  output  SW  frame sum, modulo 2^SW
- out_err  output  1  framing mismatch flag for this result

Behaviour:
- Clock/reset: one clock clk; reset rst is synchronous and active-high.
- Reset values:
  - state=FILL
  - in_ready=1, out_valid=0, out_sum=0, out_err=0
  - all buf elements=0
  - index counters i=j=k=0
- Reset mid-operation (any state) discards the frame and the partial sum.
- Let N = D0*D1*D2.

FILL state:
- in_ready=1. An element is accepted on an edge where in_valid && in_ready.
- On acceptance, write buf[i][j][k] <= in_data and advance the indices.
- Index advance: k increments; on k==D2-1, k wraps to 0 and j increments; on j==D1-1, j wraps to 0 and i increments.
- Leave FILL on acceptance with in_last=1 OR at index (D0-1,D1-1,D2-1).
- Error flag: err <= 1 if exactly one of those two conditions holds on the final accept; otherwise err <= 0.
- Early in_last: elements not written this frame stay 0.
- Next state is SUM, with indices reset to 0 and acc=0.

SUM state:
- in_ready=0.
- Each cycle: acc <= acc + sign_extend(buf[i][j][k], SW); advance the indices as in FILL.
- Exactly N cycles, always over the full array regardless of an early in_last.
- After the element at (D0-1,D1-1,D2-1), go to HOLD with out_sum <= final acc and out_err <= err.

Latency:
- The last input is accepted at edge t0. SUM occupies cycles t0+1..t0+N.
- out_valid is first high in cycle t0+N+1.

HOLD state:
- out_valid=1; in_ready=0.
- out_sum and out_err are held stable while out_ready=0.
- On the edge where out_valid && out_ready:
  - clear all buf elements to 0 in that single cycle
  - set indices to 0
  - state=FILL, out_valid=0
  - out_sum keeps its last value

Other rules:
- Overflow: the sum wraps modulo 2^SW; there is no saturation or flag.
- There is no combinational path from in_valid or out_ready to in_ready/out_valid; both are decoded from registered state only.
- Input is ignored whenever in_ready=0, even if in_valid=1.

Decomposition:
- Package array3d_frame_pkg holds:
  - state enum {FILL, SUM, HOLD}
  - index typedefs sized $clog2 of each dimension (minimum 1 bit)
  - function sign-extending W to SW
- Sub-module array3d_index_walker:
  - inputs: clk, rst, clear, step
  - outputs: i, j, k, at_end
  - implements the nested wrap counter
  - one instance, shared by FILL and SUM, since the two states are exclusive

Test Plan (D0=2, D1=3, D2=4, W=16, SW=32, N=24):
1. Reset: hold rst 2 cycles -> in_ready=1, out_valid=0, out_sum=0, out_err=0. Asserting rst during SUM -> same values next cycle, and a following clean frame sums correctly.
2. Frame of 24 zeros except elements 11 and 23 =1, in_last on element 23 -> out_valid first high 25 cycles after the last accept edge; out_sum=2; out_err=0.
3. Frame of 24 x 16'hFFFF -> out_sum=32'hFFFFFFE8 (-24); out_err=0.
4. Elements 1..6 with in_last on the 6th -> SUM still lasts 24 cycles; out_sum=21; out_err=1. Full 24-element frame without in_last -> result emitted with out_err=1.
5. Backpressure: hold out_ready=0 for 10 cycles in HOLD -> out_sum stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> in_ready=1 next cycle; the next frame of all 16'h0002 gives out_sum=48 with no residue from the prior frame.
6. Gapped input: in_valid toggles 1,0,1,0 across a 24-element frame of values 0..23 -> out_sum=276; out_err=0.
